// File: rtl/ddr_mgr_pkg.sv
// Shared types and constants for the DDR read-side line fetcher.
// Holds the FSM encoding, address field widths and data defaults.
package ddr_mgr_pkg;

    localparam int ROW_W  = 13;
    localparam int COL_W  = 10;
    localparam int BANK_W = 2;
    localparam int ADDR_W = ROW_W + COL_W + BANK_W;

    localparam logic [ROW_W-1:0] MAX_ROW_DEF  = 13'h02FF;
    localparam logic [COL_W-1:0] XFR_LEN_DEF  = 10'h200;
    localparam logic [31:0]      EXP_DATA_DEF = 32'hFDCB8610;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        XFER,
        DONE
    } lf_state_e;

    // Line requests always start at column 0, bank 0 of the row.
    function automatic logic [ADDR_W-1:0] make_addr(input logic [ROW_W-1:0] row);
        return {row, {COL_W{1'b0}}, {BANK_W{1'b0}}};
    endfunction

endpackage

// File: rtl/rd_data_chk.sv
// Compares accepted read beats against the expected word.
// Keeps a sticky fault flag and a saturating error counter.
module rd_data_chk
    import ddr_mgr_pkg::*;
#(
    parameter logic [31:0] EXP_DATA = EXP_DATA_DEF,
    parameter bit          CHK_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        beat_vld,
    input  logic [31:0] beat_data,
    output logic        data_fault,
    output logic [7:0]  err_cnt
);

    logic mis;

    assign mis = CHK_EN && beat_vld && (beat_data != EXP_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_fault <= 1'b0;
            err_cnt    <= 8'h00;
        end else if (mis) begin
            data_fault <= 1'b1;
            if (err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'h01;
        end
    end

endmodule

// File: rtl/line_fetch.sv
// Fetches one frame line per DDR read request and forwards the beats
// to the display stage, tracking rows, frames and protocol faults.
module line_fetch
    import ddr_mgr_pkg::*;
#(
    parameter logic [12:0] MAX_ROW  = MAX_ROW_DEF,
    parameter logic [9:0]  XFR_LEN  = XFR_LEN_DEF,
    parameter logic [31:0] EXP_DATA = EXP_DATA_DEF,
    parameter bit          CHK_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic        rd_mem_req,
    output logic [24:0] rd_mem_addr,
    output logic [9:0]  rd_xfr_len,
    input  logic        rd_mem_grant,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    output logic        busy,
    output logic        line_done,
    output logic        frame_done,
    output logic [12:0] cur_row,
    output logic [15:0] frame_cnt,
    output logic        frame_ovf,
    output logic        data_fault,
    output logic        len_fault,
    output logic        stray_fault,
    output logic [7:0]  err_cnt
);

    lf_state_e   state;
    lf_state_e   state_nxt;
    logic        run;
    logic [9:0]  beat_cnt;
    logic        go;
    logic        fresh;
    logic        accept;
    logic        stray;
    logic        last_beat;
    logic        len_short;
    logic        frame_end;

    assign go        = (state == IDLE) && !stop && (start || run);
    assign fresh     = (state == IDLE) && start && !stop && !run;
    assign accept    = rd_data_valid && ((state == WAIT_DATA) || (state == XFER));
    assign stray     = rd_data_valid && !((state == WAIT_DATA) || (state == XFER));
    assign last_beat = accept && ((beat_cnt + 10'd1) == XFR_LEN);
    assign len_short = (state == XFER) && !rd_data_valid;
    assign frame_end = cur_row == MAX_ROW;

    always_comb begin
        state_nxt  = state;
        busy       = state != IDLE;
        line_done  = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (go)
                    state_nxt = REQ;
            end
            REQ: begin
                if (rd_mem_grant)
                    state_nxt = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (rd_data_valid)
                    state_nxt = last_beat ? DONE : XFER;
            end
            XFER: begin
                if (len_short || last_beat)
                    state_nxt = DONE;
            end
            DONE: begin
                line_done  = 1'b1;
                frame_done = frame_end;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            run         <= 1'b0;
            rd_mem_req  <= 1'b0;
            rd_mem_addr <= '0;
            rd_xfr_len  <= '0;
            beat_cnt    <= '0;
            cur_row     <= '0;
            frame_cnt   <= '0;
            frame_ovf   <= 1'b0;
            len_fault   <= 1'b0;
            stray_fault <= 1'b0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
        end else begin
            state <= state_nxt;

            // stop always wins; the open line still runs to completion
            if (stop)
                run <= 1'b0;
            else if (start)
                run <= 1'b1;

            if (go) begin
                rd_mem_req  <= 1'b1;
                rd_mem_addr <= make_addr(fresh ? 13'd0 : cur_row);
                rd_xfr_len  <= XFR_LEN;
            end else if ((state == REQ) && rd_mem_grant) begin
                rd_mem_req <= 1'b0;
            end

            if (fresh)
                cur_row <= '0;

            if (state == DONE)
                beat_cnt <= '0;
            else if (accept)
                beat_cnt <= beat_cnt + 10'd1;

            if (state == DONE) begin
                if (frame_end) begin
                    cur_row   <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                    if (frame_cnt == 16'hFFFF)
                        frame_ovf <= 1'b1;
                end else begin
                    cur_row <= cur_row + 13'd1;
                end
            end

            if (len_short)
                len_fault <= 1'b1;
            if (stray)
                stray_fault <= 1'b1;

            pix_valid <= accept;
            if (accept)
                pix_data <= rd_data;
        end
    end

    rd_data_chk #(
        .EXP_DATA (EXP_DATA),
        .CHK_EN   (CHK_EN)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .beat_vld   (accept),
        .beat_data  (rd_data),
        .data_fault (data_fault),
        .err_cnt    (err_cnt)
    );

endmodule

// File: tb/tb_line_fetch.sv
// Directed bench for line_fetch: single lines, data/length faults,
// stop/reset behaviour and a full frame on a short-line instance.
module tb_line_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, stop, grant, rd_data_valid;
    logic [31:0] rd_data;

    logic        req0, pv0, busy0, ld0_o, fd0_o, ovf0, df0, lf0, sf0;
    logic [24:0] addr0;
    logic [9:0]  len0;
    logic [31:0] pd0;
    logic [12:0] row0;
    logic [15:0] fc0;
    logic [7:0]  ec0;

    logic        req1, pv1, busy1, ld1_o, fd1_o, ovf1, df1, lf1, sf1;
    logic [24:0] addr1;
    logic [9:0]  len1;
    logic [31:0] pd1;
    logic [12:0] row1;
    logic [15:0] fc1;
    logic [7:0]  ec1;

    line_fetch dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .rd_mem_req(req0), .rd_mem_addr(addr0), .rd_xfr_len(len0),
        .rd_mem_grant(grant), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .pix_data(pd0), .pix_valid(pv0), .busy(busy0),
        .line_done(ld0_o), .frame_done(fd0_o), .cur_row(row0),
        .frame_cnt(fc0), .frame_ovf(ovf0), .data_fault(df0),
        .len_fault(lf0), .stray_fault(sf0), .err_cnt(ec0)
    );

    line_fetch #(
        .MAX_ROW(13'h02FF), .XFR_LEN(10'd4),
        .EXP_DATA(32'hFDCB8610), .CHK_EN(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .rd_mem_req(req1), .rd_mem_addr(addr1), .rd_xfr_len(len1),
        .rd_mem_grant(grant), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .pix_data(pd1), .pix_valid(pv1), .busy(busy1),
        .line_done(ld1_o), .frame_done(fd1_o), .cur_row(row1),
        .frame_cnt(fc1), .frame_ovf(ovf1), .data_fault(df1),
        .len_fault(lf1), .stray_fault(sf1), .err_cnt(ec1)
    );

    int total = 0;
    int bad   = 0;
    int ld0 = 0, fd0 = 0, rq0 = 0;
    int ld1 = 0, fd1 = 0, rq1 = 0;
    logic req0_q = 1'b0, req1_q = 1'b0;
    logic        pix_v_bad;
    logic [31:0] pix_d_bad;

    always @(negedge clk) begin
        if (ld0_o) ld0++;
        if (fd0_o) fd0++;
        if (ld1_o) ld1++;
        if (fd1_o) fd1++;
        if (req0 && !req0_q) rq0++;
        if (req1 && !req1_q) rq1++;
        req0_q = req0;
        req1_q = req1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic req_of(input int sel);
        return (sel != 0) ? req1 : req0;
    endfunction

    function automatic logic ld_of(input int sel);
        return (sel != 0) ? ld1_o : ld0_o;
    endfunction

    // Grant 3 cycles after req, then nbeats contiguous beats.
    task automatic do_line(input int sel, input int nbeats, input int bad_idx, input bit do_stop);
        int n;
        n = 0;
        while (!req_of(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 32'(req_of(sel)), 1);
        stop = do_stop;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        grant = 1'b1;
        @(negedge clk);
        grant = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            rd_data_valid = 1'b1;
            rd_data = (i == bad_idx) ? 32'h0 : 32'hFDCB8610;
            @(negedge clk);
            if (i == bad_idx) begin
                pix_v_bad = pv0;
                pix_d_bad = pd0;
            end
        end
        rd_data_valid = 1'b0;
        rd_data = 32'h0;
        n = 0;
        while (!ld_of(sel) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("line_done_seen", 32'(ld_of(sel)), 1);
        @(negedge clk);
    endtask

    task automatic chk_reset0();
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_req", 32'(req0), 0);
        chk("rst_addr", 32'(addr0), 0);
        chk("rst_len", 32'(len0), 0);
        chk("rst_row", 32'(row0), 0);
        chk("rst_fcnt", 32'(fc0), 0);
        chk("rst_ovf", 32'(ovf0), 0);
        chk("rst_dfault", 32'(df0), 0);
        chk("rst_lfault", 32'(lf0), 0);
        chk("rst_sfault", 32'(sf0), 0);
        chk("rst_errcnt", 32'(ec0), 0);
        chk("rst_pvalid", 32'(pv0), 0);
        chk("rst_pdata", pd0, 0);
        chk("rst_ldone", 32'(ld0_o), 0);
        chk("rst_fdone", 32'(fd0_o), 0);
    endtask

    initial begin
        int b_ld, b_rq, b_fd, n;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        grant = 1'b0;
        rd_data_valid = 1'b0;
        rd_data = 32'h0;
        repeat (3) @(negedge clk);
        chk_reset0();
        rst = 1'b0;
        @(negedge clk);

        // single clean line, stop issued while waiting for grant
        b_ld = ld0;
        b_rq = rq0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy0), 1);
        do_line(0, 512, -1, 1'b1);
        repeat (5) @(negedge clk);
        chk("one_req", rq0 - b_rq, 1);
        chk("addr_row0", 32'(addr0), 32'h0);
        chk("xfr_len", 32'(len0), 32'h200);
        chk("one_line_done", ld0 - b_ld, 1);
        chk("row_after_line", 32'(row0), 1);
        chk("idle_after_stop", 32'(busy0), 0);
        chk("clean_dfault", 32'(df0), 0);
        chk("clean_lfault", 32'(lf0), 0);
        chk("clean_sfault", 32'(sf0), 0);

        // beat 7 corrupted
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_line(0, 512, 7, 1'b1);
        chk("bad_dfault", 32'(df0), 1);
        chk("bad_errcnt", 32'(ec0), 1);
        chk("bad_pix_valid", 32'(pix_v_bad), 1);
        chk("bad_pix_data", pix_d_bad, 32'h0);
        chk("bad_row_restart", 32'(row0), 1);
        chk("bad_no_lfault", 32'(lf0), 0);

        // short line, then stop on the following line
        b_ld = ld0;
        b_rq = rq0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_line(0, 100, -1, 1'b0);
        chk("short_lfault", 32'(lf0), 1);
        @(negedge clk);
        chk("next_req", 32'(req0), 1);
        chk("next_addr", 32'(addr0), 32'h1000);
        do_line(0, 512, -1, 1'b1);
        repeat (5) @(negedge clk);
        chk("stop_idle", 32'(busy0), 0);
        chk("stop_row", 32'(row0), 2);
        chk("stop_lines", ld0 - b_ld, 2);
        chk("stop_reqs", rq0 - b_rq, 2);

        // reset in the middle of a line
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!req0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_run_req", 32'(req0), 1);
        repeat (2) @(negedge clk);
        grant = 1'b1;
        @(negedge clk);
        grant = 1'b0;
        rd_data_valid = 1'b1;
        rd_data = 32'hFDCB8610;
        repeat (50) @(negedge clk);
        b_ld = ld0;
        rst = 1'b1;
        rd_data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset0();
        chk("rst_no_ldone", ld0 - b_ld, 0);
        rd_data_valid = 1'b1;
        @(negedge clk);
        rd_data_valid = 1'b0;
        @(negedge clk);
        chk("idle_stray", 32'(sf0), 1);
        chk("idle_no_pix", 32'(pv0), 0);
        chk("idle_stays", 32'(busy0), 0);

        // full frame on 4-beat lines, checking off
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        b_fd = fd1;
        b_rq = rq1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int l = 0; l < 768; l++)
            do_line(1, 4, (l == 0) ? 1 : -1, l == 767);
        chk("frame_row_wrap", 32'(row1), 0);
        chk("frame_done_once", fd1 - b_fd, 1);
        chk("frame_cnt", 32'(fc1), 1);
        chk("frame_no_ovf", 32'(ovf1), 0);
        chk("nochk_dfault", 32'(df1), 0);
        chk("nochk_errcnt", 32'(ec1), 0);
        chk("frame_lfault", 32'(lf1), 0);
        chk("frame_sfault", 32'(sf1), 0);
        repeat (5) @(negedge clk);
        chk("frame_idle", 32'(busy1), 0);
        chk("frame_reqs", rq1 - b_rq, 768);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_fetch.md
LINE_FETCH -- requirements
Module: line_fetch

Interface
REQ-001 Parameters SHALL be, name/default/meaning: MAX_ROW 13'h02FF, last row of a frame; XFR_LEN 10'h200, 32-bit beats per line; EXP_DATA 32'hFDCB8610, expected read word; CHK_EN 1, enables the data compare.
REQ-002 Ports SHALL be, name/direction/width/meaning: clk in 1 clock; rst in 1 reset.
REQ-003 start in 1 (pulse, begin fetching at row 0); stop in 1 (pulse, halt at the next line boundary).
REQ-004 rd_mem_req out 1; rd_mem_addr out 25 = {row[12:0], col[9:0], bank[1:0]}; rd_xfr_len out 10; rd_mem_grant in 1.
REQ-005 rd_data in 32; rd_data_valid in 1.
REQ-006 pix_data out 32; pix_valid out 1: registered copy of each accepted beat, for the display stage.
REQ-007 Status outputs: busy 1; line_done 1 (pulse); frame_done 1 (pulse); cur_row 13; frame_cnt 16; frame_ovf 1; data_fault 1; len_fault 1; stray_fault 1; err_cnt 8.
REQ-008 The block SHALL have one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-009 FSM states SHALL be IDLE, REQ, WAIT_DATA, XFER, DONE.
REQ-010 IDLE->REQ when start=1 or run=1 (run is set by start and cleared by stop). On that transition latch rd_mem_addr={cur_row, 10'h0, 2'b00} and rd_xfr_len=XFR_LEN.
REQ-011 REQ: rd_mem_req=1, held until rd_mem_grant=1. On the grant cycle go to WAIT_DATA; rd_mem_req is 0 from the next cycle.
REQ-012 WAIT_DATA->XFER on the first rd_data_valid=1. That beat is counted, so beat_cnt=1 in XFER.
REQ-013 XFER: every rd_data_valid=1 cycle increments the 10-bit beat_cnt. Reaching XFR_LEN goes to DONE.
REQ-014 XFER: rd_data_valid=0 with beat_cnt<XFR_LEN sets sticky len_fault and goes to DONE (valid is contiguous per line by contract).
REQ-015 DONE lasts 1 cycle: line_done=1 and beat_cnt clears.
REQ-016 In DONE, if cur_row==MAX_ROW: cur_row wraps to 0, frame_done=1 and frame_cnt increments.
REQ-017 Otherwise in DONE: cur_row+1. DONE then goes to IDLE.
REQ-018 frame_cnt wraps 16'hFFFF->0 and sets sticky frame_ovf.
REQ-019 pix_data/pix_valid SHALL equal rd_data/rd_data_valid, gated to WAIT_DATA/XFER, delayed 1 cycle.
REQ-020 rd_data_valid=1 in IDLE, REQ or DONE sets sticky stray_fault. The beat is dropped and not forwarded.
REQ-021 When CHK_EN=1, each accepted beat with rd_data!=EXP_DATA sets sticky data_fault and increments err_cnt, saturating at 8'hFF.
REQ-022 stop is honoured only in IDLE/DONE. A stop during a line completes that line first. start with run=1 is ignored.
REQ-023 start while not busy resets cur_row to 0; frame_cnt is not reset by start.
REQ-024 busy=1 in any state other than IDLE.
REQ-025 Simultaneous start and stop in the same cycle: stop wins, run=0, no request issued.

Reset
REQ-026 rst SHALL force IDLE, run=0 and rd_mem_req=0.
REQ-027 rst SHALL set rd_mem_addr=0, rd_xfr_len=0, beat_cnt=0 and cur_row=0.
REQ-028 rst SHALL clear frame_cnt, all sticky faults, err_cnt, pix_valid and all pulses; pix_data=0.
REQ-029 rst mid-line SHALL abandon the line without a line_done pulse; beats arriving afterwards in IDLE count as stray_fault.

Structure
REQ-030 A shared package ddr_mgr_pkg SHALL hold the state encoding, address field widths (13/10/2), the XFR_LEN default and the EXP_DATA default.
REQ-031 One sub-module rd_data_chk SHALL hold the compare, data_fault and the saturating err_cnt; the FSM and counters stay in line_fetch.

Verification
REQ-032 start, grant 3 cycles after req, 512 valid beats of 32'hFDCB8610 -> one req, addr=25'h0, len=10'h200, line_done once, cur_row=1, no faults.
REQ-033 Run 768 lines -> frame_done once on the row 0x2FF line, cur_row=0, frame_cnt=1.
REQ-034 Line with beat 7 = 32'h0 -> data_fault=1, err_cnt=1; with CHK_EN=0 -> no fault.
REQ-035 Valid drops after 100 beats -> len_fault=1, line_done, next request at row+1.
REQ-036 stop mid-line then rst mid-line on a second run -> first line completes and stops; after rst all outputs are at reset values and a valid pulse in IDLE gives stray_fault=1.
